// File: rtl/uart_write.sv
//==============================================================================
// Module   : uart_write
// Brief    : Store-side MMIO controller. Decodes CPU stores into the MMIO
//            window, holds one TX byte behind a valid/ready handshake, owns the
//            cycle/instruction counters and pops the UART receiver on RX reads.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_write (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_sel,
    input  logic [7:0]  addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        inst_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        rx_ready,
    output logic        tx_overrun,
    output logic [31:0] cyc_count,
    output logic [31:0] inst_count
);

    localparam logic [7:0] c_ADDR_RXDATA = 8'h04;
    localparam logic [7:0] c_ADDR_TXDATA = 8'h08;
    localparam logic [7:0] c_ADDR_CNTRST = 8'h18;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } tx_state_t;

    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        overrun_q, overrun_d;
    logic        rx_ready_q;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] inst_q, inst_d;

    // Access decode; only byte lane 0 matters for the TX register.
    logic w_tx_store;
    logic w_cnt_rst;
    logic w_rx_read;

    assign w_tx_store = mmio_sel & (addr == c_ADDR_TXDATA) & we[0];
    assign w_cnt_rst  = mmio_sel & (addr == c_ADDR_CNTRST) & (we != 4'b0000);
    assign w_rx_read  = mmio_sel & rd_en & (addr == c_ADDR_RXDATA);

    // TX holding register state, data, overrun flag and the RX pop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
            rx_ready_q <= w_rx_read;
        end
    end

    // Next-state logic: a byte leaves on valid&ready; a store into a FULL
    // register that is not draining this cycle is dropped and flagged.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        overrun_d = overrun_q;
        case (state_q)
            EMPTY: begin
                if (w_tx_store) begin
                    tx_data_d = wdata[7:0];
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (tx_ready) begin
                    if (w_tx_store) begin
                        tx_data_d = wdata[7:0];
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (w_tx_store) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (w_cnt_rst) begin
            overrun_d = 1'b0;
        end
    end

    // Counter next values; the counter-reset store beats any increment.
    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        inst_d = inst_valid ? (inst_q + 32'd1) : inst_q;
        if (w_cnt_rst) begin
            cyc_d  = 32'd0;
            inst_d = 32'd0;
        end
    end

    // Cycle and retired-instruction counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q  <= 32'd0;
            inst_q <= 32'd0;
        end else begin
            cyc_q  <= cyc_d;
            inst_q <= inst_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = (state_q == FULL);
    assign tx_overrun = overrun_q;
    assign rx_ready   = rx_ready_q;
    assign cyc_count  = cyc_q;
    assign inst_count = inst_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_write.sv
//==============================================================================
// Module   : tb_uart_write
// Brief    : Directed self-checking bench for uart_write.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_write;

    logic        clk;
    logic        rst;
    logic        mmio_sel;
    logic [7:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        rd_en;
    logic        inst_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        rx_ready;
    logic        tx_overrun;
    logic [31:0] cyc_count;
    logic [31:0] inst_count;

    int checks = 0;
    int errors = 0;

    // Bytes accepted by the transmitter, captured on each handshake edge.
    logic [7:0] sent_q[$];

    uart_write dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_sel   (mmio_sel),
        .addr       (addr),
        .we         (we),
        .wdata      (wdata),
        .rd_en      (rd_en),
        .inst_valid (inst_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .rx_ready   (rx_ready),
        .tx_overrun (tx_overrun),
        .cyc_count  (cyc_count),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that transfers (tx_valid & tx_ready at the edge).
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            sent_q.push_back(tx_data);
        end
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        mmio_sel = 1'b0;
        addr     = 8'h00;
        we       = 4'b0000;
        wdata    = 32'h0;
        rd_en    = 1'b0;
    endtask

    task automatic store(input logic sel, input logic [7:0] a,
                         input logic [3:0] w, input logic [31:0] d);
        mmio_sel = sel;
        addr     = a;
        we       = w;
        wdata    = d;
        rd_en    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        inst_valid = 1'b0;
        tx_ready   = 1'b0;
        tick(2);
        if ({tx_valid, tx_data, rx_ready, tx_overrun} !== 11'h0 ||
            cyc_count !== 32'd0 || inst_count !== 32'd0) begin
            $display("FAIL reset_state: valid=%0b data=%h rx=%0b ovr=%0b cyc=%0d inst=%0d required all 0",
                     tx_valid, tx_data, rx_ready, tx_overrun, cyc_count, inst_count);
            errors++;
        end
        checks++;
        rst = 1'b0;
        tick(5);
        if (cyc_count !== 32'd5 || inst_count !== 32'd0 || tx_valid !== 1'b0) begin
            $display("FAIL idle5: cyc=%0d inst=%0d valid=%0b required cyc=5 inst=0 valid=0",
                     cyc_count, inst_count, tx_valid);
            errors++;
        end
        checks++;
        // Asynchronous assertion, no clock edge in between.
        #2 rst = 1'b1;
        #1;
        if (cyc_count !== 32'd0) begin
            $display("FAIL async_rst_cnt: cyc=%0d required 0", cyc_count);
            errors++;
        end
        checks++;
        tick(1);
        rst = 1'b0;
        tick(1);
        if (cyc_count !== 32'd1) begin
            $display("FAIL rst_release: cyc=%0d required 1", cyc_count);
            errors++;
        end
        checks++;
    endtask

    task automatic test_tx_single();
        // Upper lanes only: not a TX store.
        store(1'b1, 8'h08, 4'b1110, 32'h0000_0077);
        tick(1);
        if (tx_valid !== 1'b0) begin
            $display("FAIL we_upper_ignored: valid=%0b required 0", tx_valid);
            errors++;
        end
        checks++;
        // mmio_sel low: no effect.
        store(1'b0, 8'h08, 4'b0001, 32'h0000_0066);
        tick(1);
        if (tx_valid !== 1'b0) begin
            $display("FAIL sel_low_tx: valid=%0b required 0", tx_valid);
            errors++;
        end
        checks++;
        store(1'b1, 8'h08, 4'b0001, 32'h1234_5641);
        tick(1);
        idle_bus();
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            $display("FAIL tx_latch: valid=%0b data=%h required valid=1 data=41", tx_valid, tx_data);
            errors++;
        end
        checks++;
        tick(3);
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            $display("FAIL tx_hold: valid=%0b data=%h required valid=1 data=41", tx_valid, tx_data);
            errors++;
        end
        checks++;
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        if (tx_valid !== 1'b0) begin
            $display("FAIL tx_drain: valid=%0b required 0", tx_valid);
            errors++;
        end
        checks++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'h41) begin
            $display("FAIL tx_sent_once: count=%0d required 1 byte 41", sent_q.size());
            errors++;
        end
        checks++;
        sent_q.delete();
    endtask

    task automatic test_overrun();
        store(1'b1, 8'h08, 4'b0001, 32'h0000_0041);
        tick(1);
        store(1'b1, 8'h08, 4'b0001, 32'h0000_0055);
        tick(1);
        idle_bus();
        if (tx_data !== 8'h41 || tx_overrun !== 1'b1 || tx_valid !== 1'b1) begin
            $display("FAIL overrun: data=%h ovr=%0b valid=%0b required data=41 ovr=1 valid=1",
                     tx_data, tx_overrun, tx_valid);
            errors++;
        end
        checks++;
        inst_valid = 1'b1;
        tick(3);
        inst_valid = 1'b0;
        if (inst_count !== 32'd3) begin
            $display("FAIL inst_count: inst=%0d required 3", inst_count);
            errors++;
        end
        checks++;
        // Counter reset with an instruction retiring in the same cycle.
        inst_valid = 1'b1;
        store(1'b1, 8'h18, 4'b0100, 32'hFFFF_FFFF);
        tick(1);
        inst_valid = 1'b0;
        idle_bus();
        if (tx_overrun !== 1'b0 || cyc_count !== 32'd0 || inst_count !== 32'd0) begin
            $display("FAIL cnt_rst: ovr=%0b cyc=%0d inst=%0d required all 0",
                     tx_overrun, cyc_count, inst_count);
            errors++;
        end
        checks++;
        tick(1);
        if (cyc_count !== 32'd1) begin
            $display("FAIL cnt_after_rst: cyc=%0d required 1", cyc_count);
            errors++;
        end
        checks++;
        // Asynchronous reset while FULL discards the byte immediately.
        #2 rst = 1'b1;
        #1;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            $display("FAIL async_rst_full: valid=%0b data=%h required valid=0 data=00", tx_valid, tx_data);
            errors++;
        end
        checks++;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_back_to_back();
        sent_q.delete();
        tx_ready = 1'b1;
        store(1'b1, 8'h08, 4'b0001, 32'h0000_00A0);
        tick(1);
        store(1'b1, 8'h08, 4'b0001, 32'h0000_00A1);
        tick(1);
        store(1'b1, 8'h08, 4'b0001, 32'h0000_00A2);
        tick(1);
        idle_bus();
        tick(1);
        tx_ready = 1'b0;
        if (sent_q.size() != 3) begin
            $display("FAIL b2b_count: count=%0d required 3", sent_q.size());
            errors++;
        end else if (sent_q[0] !== 8'hA0 || sent_q[1] !== 8'hA1 || sent_q[2] !== 8'hA2) begin
            $display("FAIL b2b_order: got %h %h %h required A0 A1 A2", sent_q[0], sent_q[1], sent_q[2]);
            errors++;
        end
        checks++;
        if (tx_overrun !== 1'b0 || tx_valid !== 1'b0) begin
            $display("FAIL b2b_end: ovr=%0b valid=%0b required 0 0", tx_overrun, tx_valid);
            errors++;
        end
        checks++;
    endtask

    task automatic test_counter_priority();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        // Store to 0x10 and a deselected store to 0x18 must not disturb counting.
        store(1'b1, 8'h10, 4'b1111, 32'h0000_0000);
        tick(1);
        store(1'b0, 8'h18, 4'b1111, 32'h0000_0000);
        tick(1);
        idle_bus();
        if (cyc_count !== 32'd6) begin
            $display("FAIL no_effect_stores: cyc=%0d required 6", cyc_count);
            errors++;
        end
        checks++;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        store(1'b1, 8'h18, 4'b0001, 32'h0);
        tick(1);
        idle_bus();
        if (cyc_count !== 32'd0) begin
            $display("FAIL cnt_rst_prio: cyc=%0d required 0", cyc_count);
            errors++;
        end
        checks++;
    endtask

    task automatic test_rx();
        mmio_sel = 1'b1;
        addr     = 8'h04;
        rd_en    = 1'b1;
        tick(1);
        idle_bus();
        if (rx_ready !== 1'b1) begin
            $display("FAIL rx_pulse: rx_ready=%0b required 1", rx_ready);
            errors++;
        end
        checks++;
        tick(1);
        if (rx_ready !== 1'b0) begin
            $display("FAIL rx_pulse_end: rx_ready=%0b required 0", rx_ready);
            errors++;
        end
        checks++;
        mmio_sel = 1'b0;
        addr     = 8'h04;
        rd_en    = 1'b1;
        tick(1);
        if (rx_ready !== 1'b0) begin
            $display("FAIL rx_sel_low: rx_ready=%0b required 0", rx_ready);
            errors++;
        end
        checks++;
        mmio_sel = 1'b1;
        addr     = 8'h00;
        tick(1);
        idle_bus();
        if (rx_ready !== 1'b0) begin
            $display("FAIL rx_addr0: rx_ready=%0b required 0", rx_ready);
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_overrun();
        test_back_to_back();
        test_counter_priority();
        test_rx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_write.md
# uart_write

Store-side memory-mapped I/O controller for the RISC-V core: the write-direction counterpart of the MMIO load mux. It decodes CPU stores into the MMIO window and drives a one-byte transmit holding register with a valid/ready handshake into the UART transmitter. It also owns the cycle and instruction counters that the load mux reports, and pulses the UART receiver's ready line when the CPU reads the receive-data register. It sits between the memory stage of the pipeline and the UART TX/RX blocks.

## Interface
- No parameters. The MMIO map is fixed:
  - 0x00 control (read-only)
  - 0x04 RX data
  - 0x08 TX data
  - 0x10 cycle count
  - 0x14 instruction count
  - 0x18 counter reset
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- mmio_sel  input  1  access targets the MMIO window; the upstream decode of address nibble 4'h8
- addr  input  8  low byte of the access address
- we  input  4  byte write enables of the store; all-zero means no store
- wdata  input  32  store data
- rd_en  input  1  load strobe from the memory stage
- inst_valid  input  1  one instruction retires this cycle
- tx_ready  input  1  UART transmitter can accept a byte
- tx_data  output  8  transmit holding register
- tx_valid  output  1  tx_data holds an unsent byte
- rx_ready  output  1  one-cycle pop of the UART receiver's byte
- tx_overrun  output  1  sticky flag: a TX store was dropped
- cyc_count  output  32  cycle counter
- inst_count  output  32  retired-instruction counter

## Operation
- A TX store is `mmio_sel & (addr==8'h08) & we[0]`.
  - Only wdata[7:0] is used.
  - we[3:1] are ignored for this register.
- TX holding register has two states: EMPTY (tx_valid=0) and FULL (tx_valid=1).
  - EMPTY + TX store → latch wdata[7:0] into tx_data; go FULL.
  - FULL + tx_ready, no store → go EMPTY. tx_data keeps its value and is don't-care.
  - FULL + tx_ready + TX store in the same cycle → latch the new byte and stay FULL. The old byte counts as sent.
  - FULL + no tx_ready + TX store → drop the store. tx_data is unchanged; set tx_overrun.
- tx_data must not change while FULL unless the current byte is accepted that cycle.
- A counter-reset store is `mmio_sel & (addr==8'h18) & (we!=0)`. It zeroes both counters; wdata is ignored. It also clears tx_overrun.
- cyc_count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
- inst_count increments by 1 on each cycle with inst_valid and wraps the same way.
- The counter reset has priority over any increment in the same cycle: the result is 0, not 1.
- An RX read is `mmio_sel & rd_en & (addr==8'h04)`. rx_ready is a registered pulse high for the single cycle after each RX read cycle. A held rd_en gives one pulse per cycle held. Upstream guarantees rd_en is a single-cycle strobe per load.
- Stores to 0x00, 0x04, 0x10 and 0x14 have no effect.
- Any access with mmio_sel=0 has no effect, whatever the addr.
- Stores and loads are never asserted in the same cycle.

## Timing
- Reset values (asynchronous, immediate on rst rising): tx_valid=0, tx_data=8'h00, rx_ready=0, tx_overrun=0, cyc_count=0, inst_count=0.
- Release of rst: cyc_count reads 1 after the first rising edge with rst low.
- Reset mid-transfer: the FULL byte is discarded and tx_valid drops immediately, without waiting for a clock.
- TX store at edge N → tx_valid=1 and tx_data valid from after edge N. The transfer can complete at edge N+1 at the earliest.
- Handshake: a byte transfers on any edge where tx_valid & tx_ready. tx_valid and tx_data depend only on registered state, with no combinational path from tx_ready.
- Back-to-back: with tx_ready held high and a TX store every cycle, one byte transfers per cycle with no bubble and no overrun.
- Counter-reset store at edge N → both counters read 0 after edge N. cyc_count reads 1 after N+1.
- RX read during cycle N → rx_ready high during cycle N+1 only. The load mux samples the receive byte in cycle N, before the pop.
- All outputs are registered.

## Test plan
- Reset, idle 5 cycles → cyc_count=5, inst_count=0, tx_valid=0.
  - Then rst high mid-count → all outputs 0 asynchronously.
- Store wdata=32'h1234_5641 to 0x08 with tx_ready=0 → tx_data=8'h41 and tx_valid=1 next cycle.
  - Hold 3 cycles, then raise tx_ready for 1 cycle → tx_valid=0 after that edge.
- FULL with tx_ready=0, store 8'h55 → tx_data stays 8'h41 and tx_overrun=1.
  - Then store to 0x18 → tx_overrun=0 and both counters 0.
- tx_ready high, stores of 8'hA0, A1, A2 on consecutive cycles → the transmitter sees exactly A0, A1, A2 on consecutive edges, with no overrun.
- Force cyc_count to 32'hFFFF_FFFE (run 2^32-2 cycles in sim or load through a backdoor); inst_valid high → cyc_count wraps to 0. In a separate run, a store to 0x18 in the cycle cyc_count would become 5 → cyc_count=0.
- RX reads:
  - Read of 0x04 with mmio_sel=1 → rx_ready is a single-cycle pulse one cycle later.
  - Same read with mmio_sel=0, or read of addr 0x00 → no pulse.
